// File: rtl/store_checker_pkg.sv
// store_checker_pkg: shared state encoding and fail codes for the store checker.
package store_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } checkerState;

    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_MISMATCH   = 2'b01;
    localparam logic [1:0] FC_UNEXPECTED = 2'b10;
    localparam logic [1:0] FC_TIMEOUT    = 2'b11;

endpackage

// File: rtl/store_match.sv
// store_match: combinational address matcher; the lowest valid index wins on duplicates.
module store_match #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [31:0]            adr,
    input  logic [DEPTH-1:0][31:0] entryAdr,
    input  logic [DEPTH-1:0]       valid,
    output logic                   hit,
    output logic [IDX_W-1:0]       hitIdx
);

    always_comb begin
        hit = 1'b0;
        hitIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && entryAdr[i] == adr) begin
                hit = 1'b1;
                hitIdx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/store_checker.sv
// store_checker: matches processor stores against a programmed table of expected
// (address, data) pairs and latches a sticky PASS/FAIL verdict.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_addr,
    input  logic [31:0]      cfg_data,
    input  logic             arm,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [IDX_W-1:0] fail_idx,
    output logic [31:0]      fail_adr,
    output logic [31:0]      fail_data,
    output logic [15:0]      store_cnt
);

    checkerState state, nextState;
    logic [DEPTH-1:0][31:0] tabAdr, tabData;
    logic [DEPTH-1:0] valid, seen, seenNext, hitMask;
    logic [31:0] toCnt;
    logic [IDX_W-1:0] hitIdx;
    logic [1:0] codeNext;
    logic hit, dataBad, unexpected, timeoutHit, allSeen;

    store_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) matcher (
        .adr(DataAdr),
        .entryAdr(tabAdr),
        .valid(valid),
        .hit(hit),
        .hitIdx(hitIdx)
    );

    assign hitMask    = {{(DEPTH-1){1'b0}}, 1'b1} << hitIdx;
    assign dataBad    = MemWrite && hit && tabData[hitIdx] != WriteData;
    assign unexpected = MemWrite && !hit && STRICT != 0;
    assign seenNext   = seen | (MemWrite && hit && !dataBad ? hitMask : '0);
    assign allSeen    = (valid & ~seenNext) == '0;
    assign timeoutHit = TIMEOUT != 0 && toCnt == 32'(TIMEOUT - 1);

    assign busy = state == ARMED;
    assign pass = state == PASS;
    assign fail = state == FAIL;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    // The store is judged before the timeout, so a completing store beats it.
    always_comb begin
        nextState = state;
        codeNext = FC_NONE;
        case (state)
            IDLE: nextState = arm ? ARMED : IDLE;
            ARMED: begin
                codeNext = dataBad ? FC_MISMATCH :
                           unexpected ? FC_UNEXPECTED :
                           (!allSeen && timeoutHit) ? FC_TIMEOUT : FC_NONE;
                nextState = codeNext != FC_NONE ? FAIL : allSeen ? PASS : ARMED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tabAdr <= '0;
            tabData <= '0;
            valid <= '0;
            seen <= '0;
            toCnt <= '0;
            store_cnt <= '0;
            fail_code <= FC_NONE;
            fail_idx <= '0;
            fail_adr <= '0;
            fail_data <= '0;
        end else if (state == IDLE) begin
            if (cfg_we) begin
                tabAdr[cfg_idx] <= cfg_addr;
                tabData[cfg_idx] <= cfg_data;
                valid[cfg_idx] <= 1'b1;
            end
            if (arm) begin
                seen <= '0;
                toCnt <= '0;
                store_cnt <= '0;
            end
        end else if (state == ARMED) begin
            seen <= seenNext;
            toCnt <= toCnt + 32'd1;
            if (MemWrite && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
            if (codeNext != FC_NONE) begin
                fail_code <= codeNext;
                fail_idx <= dataBad ? hitIdx : '0;
                fail_adr <= codeNext == FC_TIMEOUT ? '0 : DataAdr;
                fail_data <= codeNext == FC_TIMEOUT ? '0 : WriteData;
            end
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: directed scenarios plus randomized runs against a table-level
// reference model, on a lax (STRICT=0, TIMEOUT=16) and a strict (STRICT=1, TIMEOUT=64) instance.
module tb_store_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, MemWrite, cfg_we, arm;
    logic [31:0] DataAdr, WriteData, cfg_addr, cfg_data;
    logic [2:0] cfg_idx;
    logic [1:0] busy, pass, fail;
    logic [1:0] failCode[2];
    logic [2:0] failIdx[2];
    logic [31:0] failAdr[2], failData[2];
    logic [15:0] storeCnt[2];
    int checks = 0;
    int errors = 0;

    store_checker #(.DEPTH(8), .IDX_W(3), .TIMEOUT(16), .STRICT(0)) dutLax (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .arm(arm),
        .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .fail_code(failCode[0]), .fail_idx(failIdx[0]),
        .fail_adr(failAdr[0]), .fail_data(failData[0]), .store_cnt(storeCnt[0])
    );

    store_checker #(.DEPTH(8), .IDX_W(3), .TIMEOUT(64), .STRICT(1)) dutStrict (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .arm(arm),
        .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .fail_code(failCode[1]), .fail_idx(failIdx[1]),
        .fail_adr(failAdr[1]), .fail_data(failData[1]), .store_cnt(storeCnt[1])
    );

    // Reference model: a table of expected stores, a set of seen entries and a verdict.
    localparam int M_IDLE = 0, M_ARMED = 1, M_PASS = 2, M_FAIL = 3;
    int strictK[2] = '{0, 1};
    int timeoutK[2] = '{16, 64};
    int mState[2], mCnt[2], mTo[2], mCode[2], mIdx[2];
    bit mValid[2][8], mSeen[2][8];
    logic [31:0] mAdr[2][8], mData[2][8];
    logic [31:0] mFAdr[2], mFData[2];

    localparam logic [31:0] D0 = 32'h06890000, D1 = 32'h01B02B93, KEY = 32'hA5A50000;

    task automatic modelFail(int k, int code, int idx, logic [31:0] a, logic [31:0] d);
        mState[k] = M_FAIL;
        mCode[k] = code;
        mIdx[k] = idx;
        mFAdr[k] = a;
        mFData[k] = d;
    endtask

    task automatic modelStep(int k);
        int h;
        bit done;
        if (reset) begin
            mState[k] = M_IDLE;
            mCnt[k] = 0; mTo[k] = 0; mCode[k] = 0; mIdx[k] = 0; mFAdr[k] = 0; mFData[k] = 0;
            for (int i = 0; i < 8; i++) begin
                mValid[k][i] = 0; mSeen[k][i] = 0; mAdr[k][i] = 0; mData[k][i] = 0;
            end
        end else if (mState[k] == M_IDLE) begin
            if (cfg_we) begin
                mAdr[k][cfg_idx] = cfg_addr;
                mData[k][cfg_idx] = cfg_data;
                mValid[k][cfg_idx] = 1;
            end
            if (arm) begin
                for (int i = 0; i < 8; i++) mSeen[k][i] = 0;
                mCnt[k] = 0;
                mTo[k] = 0;
                mState[k] = M_ARMED;
            end
        end else if (mState[k] == M_ARMED) begin
            h = -1;
            for (int i = 0; i < 8; i++)
                if (h < 0 && mValid[k][i] && mAdr[k][i] == DataAdr) h = i;
            mTo[k]++;
            if (MemWrite && mCnt[k] < 65535) mCnt[k]++;
            if (MemWrite && h >= 0 && mData[k][h] != WriteData) modelFail(k, 1, h, DataAdr, WriteData);
            else if (MemWrite && h < 0 && strictK[k] == 1) modelFail(k, 2, 0, DataAdr, WriteData);
            else begin
                if (MemWrite && h >= 0) mSeen[k][h] = 1;
                done = 1;
                for (int i = 0; i < 8; i++) if (mValid[k][i] && !mSeen[k][i]) done = 0;
                if (done) mState[k] = M_PASS;
                else if (timeoutK[k] != 0 && mTo[k] == timeoutK[k]) modelFail(k, 3, 0, 0, 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    task automatic doReset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic load(int idx, logic [31:0] a, logic [31:0] d);
        cfg_we = 1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic loadPlan();
        load(0, 100, D0);
        load(1, 104, D1);
    endtask

    task automatic doArm();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        MemWrite = 1; DataAdr = a; WriteData = d;
        tick();
        MemWrite = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick(); reset = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy[k], pass[k], fail[k], failCode[k], failIdx[k], failAdr[k], failData[k], storeCnt[k]} !== '0) begin
                errors++;
                $display("FAIL reset k=%0d: got busy=%b pass=%b fail=%b code=%0d cnt=%0d, want all 0", k, busy[k], pass[k], fail[k], failCode[k], storeCnt[k]);
            end
        end
    endtask

    task automatic test_pass();
        doReset(); loadPlan(); doArm();
        store(100, D0);
        checks++;
        if (pass[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL pass_early: got pass=%b busy=%b, want 0 1", pass[0], busy[0]);
        end
        store(104, D1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pass[k] !== 1'b1 || fail[k] !== 1'b0 || storeCnt[k] !== 16'd2 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL pass k=%0d: got pass=%b fail=%b cnt=%0d busy=%b, want 1 0 2 0", k, pass[k], fail[k], storeCnt[k], busy[k]);
            end
        end
    endtask

    task automatic test_mismatch();
        doReset(); loadPlan(); doArm();
        store(104, 32'h01B02B92);
        for (int pass2 = 0; pass2 < 2; pass2++) begin
            checks++;
            if (fail[0] !== 1'b1 || pass[0] !== 1'b0 || failCode[0] !== 2'b01 || failIdx[0] !== 3'd1 ||
                failAdr[0] !== 32'd104 || failData[0] !== 32'h01B02B92 || storeCnt[0] !== 16'd1) begin
                errors++;
                $display("FAIL mismatch step=%0d: got fail=%b pass=%b code=%0d idx=%0d adr=%0d data=%h cnt=%0d, want 1 0 1 1 104 01b02b92 1",
                         pass2, fail[0], pass[0], failCode[0], failIdx[0], failAdr[0], failData[0], storeCnt[0]);
            end
            store(100, D0);
            store(104, D1);
        end
    endtask

    task automatic test_strict();
        doReset(); loadPlan(); doArm();
        store(96, 7);
        store(100, D0);
        store(104, D1);
        checks++;
        if (fail[1] !== 1'b1 || failCode[1] !== 2'b10 || failAdr[1] !== 32'd96 || failData[1] !== 32'd7 ||
            failIdx[1] !== 3'd0 || storeCnt[1] !== 16'd1) begin
            errors++;
            $display("FAIL strict: got fail=%b code=%0d adr=%0d data=%0d idx=%0d cnt=%0d, want 1 2 96 7 0 1",
                     fail[1], failCode[1], failAdr[1], failData[1], failIdx[1], storeCnt[1]);
        end
        checks++;
        if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || storeCnt[0] !== 16'd3) begin
            errors++;
            $display("FAIL lax_unexpected: got pass=%b fail=%b cnt=%0d, want 1 0 3", pass[0], fail[0], storeCnt[0]);
        end
    endtask

    task automatic test_timeout();
        doReset(); loadPlan(); doArm();
        store(100, D0);
        for (int n = 1; n <= 16; n++) begin
            if (n > 1) tick();
            checks++;
            if (fail[0] !== (n == 16)) begin
                errors++; $display("FAIL timeout_edge n=%0d: got fail=%b, want %b", n, fail[0], n == 16);
            end
        end
        checks++;
        if (failCode[0] !== 2'b11 || failAdr[0] !== 32'd0 || failData[0] !== 32'd0 || failIdx[0] !== 3'd0 ||
            busy[0] !== 1'b0 || pass[0] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got code=%0d adr=%0d data=%0d idx=%0d busy=%b pass=%b busyStrict=%b, want 3 0 0 0 0 0 1",
                     failCode[0], failAdr[0], failData[0], failIdx[0], busy[0], pass[0], busy[1]);
        end
    endtask

    task automatic test_timeout_race();
        doReset(); loadPlan(); doArm();
        store(100, D0);
        repeat (14) tick();
        store(104, D1);
        checks++;
        if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || failCode[0] !== 2'b00) begin
            errors++;
            $display("FAIL timeout_race: got pass=%b fail=%b code=%0d, want 1 0 0", pass[0], fail[0], failCode[0]);
        end
    endtask

    task automatic test_empty();
        doReset(); doArm();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy[k] !== 1'b1 || pass[k] !== 1'b0) begin
                errors++; $display("FAIL empty_armed k=%0d: got busy=%b pass=%b, want 1 0", k, busy[k], pass[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pass[k] !== 1'b1 || busy[k] !== 1'b0 || fail[k] !== 1'b0) begin
                errors++; $display("FAIL empty_pass k=%0d: got pass=%b busy=%b fail=%b, want 1 0 0", k, pass[k], busy[k], fail[k]);
            end
        end
    endtask

    task automatic test_arm_with_cfg();
        doReset();
        load(0, 100, D0);
        cfg_we = 1; cfg_idx = 3'd1; cfg_addr = 104; cfg_data = D1; arm = 1;
        tick();
        cfg_we = 0; arm = 0;
        store(100, D0);
        checks++;
        if (pass[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL arm_cfg_pending: got pass=%b busy=%b, want 0 1", pass[0], busy[0]);
        end
        store(104, D1);
        checks++;
        if (pass[0] !== 1'b1) begin
            errors++; $display("FAIL arm_cfg_pass: got pass=%b, want 1", pass[0]);
        end
    endtask

    task automatic test_reset_mid();
        doReset(); loadPlan(); doArm();
        store(100, D0);
        reset = 1; tick(); reset = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy[k], pass[k], fail[k], failCode[k], failIdx[k], failAdr[k], failData[k], storeCnt[k]} !== '0) begin
                errors++;
                $display("FAIL reset_mid k=%0d: got busy=%b pass=%b fail=%b cnt=%0d, want all 0", k, busy[k], pass[k], fail[k], storeCnt[k]);
            end
        end
        doArm();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pass[k] !== 1'b1 || storeCnt[k] !== 16'd0) begin
                errors++; $display("FAIL rearm_empty k=%0d: got pass=%b cnt=%0d, want 1 0", k, pass[k], storeCnt[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit wantBusy, wantPass, wantFail;
        for (int r = 0; r < 16; r++) begin
            doReset();
            for (int j = 0; j < int'($urandom_range(0, 7)); j++) begin
                a = 32'(4 * $urandom_range(0, 7));
                load(int'($urandom_range(0, 7)), a, ($urandom_range(0, 7) == 0) ? a ^ KEY ^ 32'h2 : a ^ KEY);
            end
            doArm();
            for (int c = 0; c < 80; c++) begin
                MemWrite = ($urandom_range(0, 2) != 0);
                DataAdr = 32'(4 * $urandom_range(0, 9));
                WriteData = ($urandom_range(0, 11) == 0) ? DataAdr ^ KEY ^ 32'h1 : DataAdr ^ KEY;
                arm = ($urandom_range(0, 7) == 0);
                cfg_we = ($urandom_range(0, 7) == 0);
                cfg_idx = 3'($urandom_range(0, 7));
                cfg_addr = DataAdr;
                cfg_data = 32'h0BAD;
                tick();
                for (int k = 0; k < 2; k++) begin
                    wantBusy = mState[k] == M_ARMED;
                    wantPass = mState[k] == M_PASS;
                    wantFail = mState[k] == M_FAIL;
                    checks++;
                    if (busy[k] !== wantBusy || pass[k] !== wantPass || fail[k] !== wantFail || failCode[k] !== 2'(mCode[k]) ||
                        failIdx[k] !== 3'(mIdx[k]) || failAdr[k] !== mFAdr[k] || failData[k] !== mFData[k] || storeCnt[k] !== 16'(mCnt[k])) begin
                        errors++;
                        $display("FAIL random r=%0d c=%0d k=%0d: got bpf=%b%b%b code=%0d idx=%0d adr=%h data=%h cnt=%0d, want bpf=%b%b%b code=%0d idx=%0d adr=%h data=%h cnt=%0d",
                                 r, c, k, busy[k], pass[k], fail[k], failCode[k], failIdx[k], failAdr[k], failData[k], storeCnt[k],
                                 wantBusy, wantPass, wantFail, mCode[k], mIdx[k], mFAdr[k], mFData[k], mCnt[k]);
                    end
                end
            end
            MemWrite = 0; arm = 0; cfg_we = 0;
        end
    endtask

    initial begin
        reset = 1; MemWrite = 0; DataAdr = 0; WriteData = 0;
        cfg_we = 0; cfg_idx = 0; cfg_addr = 0; cfg_data = 0; arm = 0;
        test_reset();
        test_pass();
        test_mismatch();
        test_strict();
        test_timeout();
        test_timeout_race();
        test_empty();
        test_arm_with_cfg();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
